alu_cmd_responder: RTL and testbench



---
 rtl/alu_cmd_responder_if.sv | 26 ++
 rtl/alu_cmd_responder.sv | 108 ++++++++++
 tb/tb_alu_cmd_responder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_responder_if.sv
// Command/result handshake bundle for alu_cmd_responder.
// master = command issuer / result consumer, slave = responder.
interface alu_cmd_responder_if #(
   parameter int unsigned WIDTH = 16
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic [1:0]       cmd_op;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_ovf;
   logic             busy;

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
      input  cmd_ready, res_valid, res_data, res_ovf, busy
   );

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
      output cmd_ready, res_valid, res_data, res_ovf, busy
   );
endinterface

// File: rtl/alu_cmd_responder.sv
// ALU command responder: one registered compute stage feeding an in-order result FIFO.
// Define ALU_SAT_EN to saturate add/sub to signed limits on overflow instead of wrapping.
module alu_cmd_responder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input logic                 clk,
   input logic                 resetn,
   alu_cmd_responder_if.slave  bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic             ovf;
      logic [WIDTH-1:0] data;
   } res_t;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [1:0]       s1_op;
   res_t             s1_res;

   res_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   outstanding;

   logic accept;
   logic push;
   logic pop;

   // Credit: a slot is reserved for every accepted command until it is popped.
   assign outstanding   = {1'b0, count} + (CNT_W+1)'(s1_valid);
   assign bus.cmd_ready = outstanding < (CNT_W+1)'(DEPTH);
   assign bus.res_valid = count != '0;
   assign bus.res_data  = bus.res_valid ? mem[rd_ptr].data : '0;
   assign bus.res_ovf   = bus.res_valid ? mem[rd_ptr].ovf  : 1'b0;
   assign bus.busy      = s1_valid || bus.res_valid;

   assign accept = bus.cmd_valid && bus.cmd_ready;
   assign push   = s1_valid;
   assign pop    = bus.res_valid && bus.res_ready;

   // ALU evaluated on the captured operands.
   always_comb begin
      s1_res = '0;
      unique case (s1_op)
         2'b00: begin
            s1_res.data = s1_a + s1_b;
            s1_res.ovf  = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                          (s1_res.data[WIDTH-1] != s1_a[WIDTH-1]);
         end
         2'b01: begin
            s1_res.data = s1_a - s1_b;
            s1_res.ovf  = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                          (s1_res.data[WIDTH-1] != s1_a[WIDTH-1]);
         end
         2'b10: s1_res.data = s1_a & s1_b;
         default: s1_res.data = s1_a ^ s1_b;
      endcase
`ifdef ALU_SAT_EN
      // On overflow the true result lies beyond the limit on A's side.
      if (s1_res.ovf) begin
         s1_res.data = s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
      end
`else
      s1_res.data = s1_res.data;
`endif
   end

   // Compute stage and FIFO control.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_a  <= bus.cmd_a;
            s1_b  <= bus.cmd_b;
            s1_op <= bus.cmd_op;
         end
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible while count covers them.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= s1_res;
   end

endmodule

// File: tb/tb_alu_cmd_responder.sv
// Randomized and directed bench for alu_cmd_responder against a queue-based reference.
module tb_alu_cmd_responder;

   localparam int unsigned W = 16;
   localparam int unsigned D = 4;

   typedef struct {
      logic [W-1:0] d;
      logic         ovf;
      int           edge_n;
   } exp_t;

   logic clk;
   logic resetn;
   alu_cmd_responder_if #(.WIDTH(W)) bus ();

   alu_cmd_responder #(.WIDTH(W), .DEPTH(D)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t q[$];
   int   edge_cnt = 0;
   int   n_cmp    = 0;
   int   n_bad    = 0;

   function automatic exp_t ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [1:0] op);
      exp_t e;
      int   r;
      e.edge_n = 0;
      e.ovf    = 1'b0;
      r        = 0;
      case (op)
         2'd0: r = int'($signed(a)) + int'($signed(b));
         2'd1: r = int'($signed(a)) - int'($signed(b));
         default: r = 0;
      endcase
      if (op == 2'd2)      e.d = a & b;
      else if (op == 2'd3) e.d = a ^ b;
      else begin
         e.ovf = (r > 32767) || (r < -32768);
`ifdef ALU_SAT_EN
         if (r > 32767)       e.d = 16'h7FFF;
         else if (r < -32768) e.d = 16'h8000;
         else                 e.d = 16'(r);
`else
         e.d = 16'(r);
`endif
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_cnt);
      end
   endtask

   function automatic logic m_valid();
      return (q.size() > 0) && (q[0].edge_n < edge_cnt);
   endfunction

   task automatic check_all();
      logic v;
      v = m_valid();
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(q.size() < D));
      chk("res_valid", 32'(bus.res_valid), 32'(v));
      chk("res_data",  32'(bus.res_data),  v ? 32'(q[0].d)   : 32'd0);
      chk("res_ovf",   32'(bus.res_ovf),   v ? 32'(q[0].ovf) : 32'd0);
      chk("busy",      32'(bus.busy),      32'(q.size() > 0));
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
      chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
      chk({tag, "_res_data"},  32'(bus.res_data),  32'd0);
      chk({tag, "_res_ovf"},   32'(bus.res_ovf),   32'd0);
      chk({tag, "_busy"},      32'(bus.busy),      32'd0);
   endtask

   // One clock: drive inputs, advance the reference on the edge, compare after it.
   task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic rr);
      logic will_acc;
      logic will_pop;
      exp_t e;
      bus.cmd_valid = v;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_op    = op;
      bus.res_ready = rr;
      will_acc = v && (q.size() < D);
      will_pop = rr && m_valid();
      @(posedge clk);
      edge_cnt++;
      if (will_pop) void'(q.pop_front());
      if (will_acc) begin
         e        = ref_alu(a, b, op);
         e.edge_n = edge_cnt;
         q.push_back(e);
      end
      #1;
      check_all();
   endtask

   task automatic idle(input logic rr);
      step(1'b0, 16'(0), 16'(0), 2'd0, rr);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      resetn        = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.cmd_op    = '0;
      bus.res_ready = 1'b0;
      #1;
      check_reset_vals("rst0");
      repeat (3) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;

      // Single add: visible two edges after accept.
      step(1'b1, 16'd3, 16'd5, 2'd0, 1'b1);
      idle(1'b1);
      chk("lat_valid", 32'(bus.res_valid), 32'd1);
      chk("lat_data",  32'(bus.res_data),  32'd8);
      idle(1'b1);
      idle(1'b1);
      chk("idle_busy", 32'(bus.busy), 32'd0);

      // Back-to-back stream with res_ready held high.
      step(1'b1, 16'd10,    16'd3,    2'd1, 1'b1);
      step(1'b1, 16'hF0F0,  16'h0FF0, 2'd2, 1'b1);
      step(1'b1, 16'hFFFF,  16'h1234, 2'd3, 1'b1);
      step(1'b1, 16'h7FFF,  16'h0001, 2'd0, 1'b1);
      step(1'b1, 16'h8000,  16'h0001, 2'd1, 1'b1);
      step(1'b1, 16'h8000,  16'h8000, 2'd0, 1'b1);
      step(1'b1, 16'h1234,  16'h4321, 2'd0, 1'b1);
      step(1'b1, 16'h0000,  16'h0001, 2'd1, 1'b1);
      chk("stream_ready", 32'(bus.cmd_ready), 32'd1);
      repeat (3) idle(1'b1);

      // Backpressure: only DEPTH accepts, head held.
      for (int i = 0; i < 8; i++) step(1'b1, 16'(100 + i), 16'(i), 2'd0, 1'b0);
      chk("bp_ready", 32'(bus.cmd_ready), 32'd0);
      chk("bp_head",  32'(bus.res_data),  32'd100);
      // Full FIFO with simultaneous pop and accept.
      for (int i = 0; i < 10; i++) step(1'b1, 16'(200 + i), 16'(i), 2'd3, 1'b1);
      repeat (6) idle(1'b1);

      // Reset with three queued results and one in compute.
      for (int i = 0; i < 4; i++) step(1'b1, 16'(300 + i), 16'd1, 2'd0, 1'b0);
      #2;
      resetn = 1'b0;
      #1;
      q.delete();
      check_reset_vals("midrst");
      bus.cmd_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         edge_cnt++;
      end
      @(negedge clk);
      resetn = 1'b1;
      #1;
      check_reset_vals("rel");
      step(1'b1, 16'd40, 16'd2, 2'd0, 1'b1);
      repeat (3) idle(1'b1);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if ($urandom_range(0, 7) == 0) ra = 16'h7FFF;
         if ($urandom_range(0, 7) == 0) rb = 16'h8000;
         step(1'($urandom_range(0, 3) != 0), ra, rb, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 2) != 0));
      end
      repeat (8) idle(1'b1);
      chk("end_busy", 32'(bus.busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
